// File: rtl/seq_alu_mac_if.sv
// rtl/seq_alu_mac_if.sv - operand/result valid-ready bundle between fetch, seq_alu_mac and activation
interface seq_alu_mac_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       opcode;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] Y;
  logic             co;

  modport master (
    output in_valid, A, B, opcode, acc_clr, out_ready,
    input  in_ready, out_valid, Y, co
  );

  modport slave (
    input  in_valid, A, B, opcode, acc_clr, out_ready,
    output in_ready, out_valid, Y, co
  );
endinterface

// File: rtl/seq_alu_mac.sv
// rtl/seq_alu_mac.sv - handshaked ALU with shift-add multiplier and MAC accumulator
// Optional macro SEQ_ALU_SAT_EN: MAC saturates at 2^ACC_W-1 instead of wrapping.
module seq_alu_mac #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 40
) (
  input  logic         clk,
  input  logic         rst,
  seq_alu_mac_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    a_q, a_d, prod_q, prod_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mac_q, mac_d;
  logic [ACC_W-1:0] acc_q, acc_d, y_q, y_d;
  logic             co_q, co_d;
`ifdef SEQ_ALU_SAT_EN
  logic             sat_q, sat_d;
`endif

  logic [WIDTH:0]   add_sum, sub_diff;
  logic [PW-1:0]    shl_res, prod_nx;
  logic [ACC_W:0]   mac_sum;

  assign add_sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_diff = {1'b0, bus.A} - {1'b0, bus.B};
  assign shl_res  = {{WIDTH{1'b0}}, bus.A} << bus.B[SW-1:0];
  // Last shift-add step and the accumulate both land on the MULT->DONE edge.
  assign prod_nx  = prod_q + (b_q[0] ? a_q : '0);
  assign mac_sum  = {1'b0, acc_q} + (ACC_W+1)'(prod_nx);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Y         = y_q;
  assign bus.co        = co_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    mac_d   = mac_q;
    acc_d   = acc_q;
    y_d     = y_q;
    co_d    = co_q;
`ifdef SEQ_ALU_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.acc_clr) begin
          acc_d = '0;
`ifdef SEQ_ALU_SAT_EN
          sat_d = 1'b0;
`endif
        end
        if (bus.in_valid) begin
          if (bus.opcode[2:1] == 2'b11) begin
            a_d     = PW'(bus.A);
            b_d     = bus.B;
            prod_d  = '0;
            cnt_d   = CW'(WIDTH);
            mac_d   = bus.opcode[0];
            state_d = MULT;
          end else begin
            state_d = DONE;
            co_d    = 1'b0;
            case (bus.opcode)
              3'b000: begin
                y_d  = ACC_W'(add_sum);
                co_d = add_sum[WIDTH];
              end
              3'b001: begin
                y_d  = ACC_W'(sub_diff[WIDTH-1:0]);
                co_d = sub_diff[WIDTH];
              end
              3'b010:  y_d = ACC_W'(bus.A & bus.B);
              3'b011:  y_d = ACC_W'(bus.A | bus.B);
              3'b100:  y_d = ACC_W'(bus.A ^ bus.B);
              default: y_d = ACC_W'(shl_res);
            endcase
          end
        end
      end
      MULT: begin
        prod_d = prod_nx;
        a_d    = a_q << 1;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          if (mac_q) begin
`ifdef SEQ_ALU_SAT_EN
            if (mac_sum[ACC_W] || sat_q) begin
              acc_d = '1;
              y_d   = '1;
              co_d  = 1'b1;
              sat_d = 1'b1;
            end else begin
              acc_d = mac_sum[ACC_W-1:0];
              y_d   = mac_sum[ACC_W-1:0];
              co_d  = 1'b0;
            end
`else
            acc_d = mac_sum[ACC_W-1:0];
            y_d   = mac_sum[ACC_W-1:0];
            co_d  = mac_sum[ACC_W];
`endif
          end else begin
            y_d  = ACC_W'(prod_nx);
            co_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      mac_q   <= 1'b0;
      acc_q   <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
`ifdef SEQ_ALU_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      mac_q   <= mac_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      co_q    <= co_d;
`ifdef SEQ_ALU_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end
endmodule

// File: doc/seq_alu_mac.md
Name: seq_alu_mac

Overview:
- Parametrised, handshaked successor to the 16-bit combinational 3-bit-opcode ALU.
- Adds registered outputs and an iterative shift-add multiplier.
- Adds a persistent accumulator for MAC, used by the neural datapath for dot products.
- Sits between the operand fetch stage and the activation stage, with valid/ready on both sides.

Parameters:
- WIDTH, 16, operand width in bits (>= 4).
- ACC_W, 40, accumulator and result width; must be >= 2*WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- opcode  in  3  operation select.
- acc_clr  in  1  clear accumulator.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- Y  out  ACC_W  result, zero-extended.
- co  out  1  carry / borrow / accumulator overflow flag.

Behaviour:
- Only one clock and one reset: clk, with rst synchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, Y=0, co=0, acc=0, iteration counter=0. Reset overrides everything, including mid-multiply and DONE; the in-flight op is discarded.
- FSM states and transitions:
  - IDLE, in_ready=1: accept when in_valid&in_ready, capturing A, B and opcode.
  - IDLE → DONE: opcodes 000-101; result registered on the accept edge.
  - IDLE → MULT: opcodes 110/111, counter loaded with WIDTH.
  - MULT, in_ready=0: one shift-add step per cycle. If B_shift[0], then prod += A_shift; then A_shift<<=1, B_shift>>=1, counter-=1. When the counter reaches 0, go to DONE on that edge.
  - DONE, in_ready=0, out_valid=1: Y and co held stable. On out_valid&out_ready → IDLE with out_valid=0. No same-cycle re-accept.
- Latency:
  - Opcodes 000-101: out_valid on the cycle after accept.
  - 110/111: out_valid WIDTH+1 cycles after accept.
  - Minimum issue interval: 2 cycles for single-cycle ops.
- Opcodes (co=0 unless stated):
  - 000 ADD: Y = A+B as WIDTH+1 bits; co = bit WIDTH.
  - 001 SUB: Y = (A-B) mod 2^WIDTH; co=1 iff A<B (borrow).
  - 010 AND: Y = A&B.
  - 011 OR: Y = A|B.
  - 100 XOR: Y = A^B.
  - 101 SHL: Y = A << B[$clog2(WIDTH)-1:0], 2*WIDTH wide, no truncation.
  - 110 MUL: Y = A*B, 2*WIDTH bits; acc untouched.
  - 111 MAC: acc_next = acc + A*B, computed mod 2^ACC_W; Y=acc_next; co=1 iff the addition carried out of ACC_W. acc updates on the MULT→DONE edge.
- acc_clr:
  - Honoured only in IDLE; ignored in MULT and DONE.
  - If asserted in the same cycle a MAC is accepted, the MAC accumulates from 0.
  - Clearing produces no out_valid.
- Inputs A, B, opcode and in_valid are ignored while in_ready=0.
- out_ready is ignored while out_valid=0.

Optional Feature:
- Macro: SEQ_ALU_SAT_EN.
- Defined: MAC saturates. If acc + A*B >= 2^ACC_W, then acc=Y=2^ACC_W-1 and co=1. Further MACs stay saturated (co=1 each time) until acc_clr or rst.
- Undefined: MAC wraps mod 2^ACC_W, with co as above.
- All other opcodes are identical in both builds.

Test Plan:
- WIDTH=16, ACC_W=40. ADD A=10,B=5 → Y=15, co=0, one cycle after accept. ADD A=16'hFFFF,B=1 → Y=40'h10000, co=1.
- SUB A=10,B=11 → Y=40'h0FFFF, co=1. SHL A=1,B=4 → Y=16. XOR A=16'hF0F0,B=16'hFF00 → Y=16'h0FF0.
- MUL A=300,B=400 → out_valid exactly 17 cycles after accept, Y=120000. in_ready=0 throughout, and acc is unchanged.
- MAC backpressure:
  - Issue acc_clr, then MAC (3,4), (5,6), (7,8) → Y = 12, 42, 98.
  - Hold out_ready=0 for 5 cycles after the second result → Y=42 and out_valid stable, in_ready=0.
- WIDTH=16, ACC_W=33, three MACs of 16'hFFFF*16'hFFFF:
  - Wrap build: third Y=4294574083, co=1.
  - SEQ_ALU_SAT_EN build: third Y=8589934591, co=1; a fourth MAC (1,1) → Y=8589934591, co=1.
- Reset in MULT:
  - Assert rst 8 cycles into MUL 300*400 → next cycle in_ready=1, out_valid=0, Y=0, acc=0.
  - Then ADD 1+2 → Y=3.
